framed_shiftregister: RTL and testbench

FRAMED_SHIFTREGISTER -- requirements
Module: framed_shiftregister

---
 rtl/framed_shiftregister.sv | 102 ++++++++++
 tb/tb_framed_shiftregister.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/framed_shiftregister.sv
// rtl/framed_shiftregister.sv - serial/parallel shift register with frame capture and overrun flag
// Optional LSB-first shifting is enabled by defining FRAMED_SR_LSB_FIRST_EN.
module framed_shiftregister #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     peripheralClkEdge,
  input  logic                     parallelLoad,
  input  logic [WIDTH-1:0]         parallelDataIn,
  input  logic                     serialDataIn,
  input  logic                     lsbFirst,
  input  logic                     frameAck,
  output logic [WIDTH-1:0]         parallelDataOut,
  output logic                     serialDataOut,
  output logic [$clog2(WIDTH)-1:0] bitCount,
  output logic                     frameDone,
  output logic [WIDTH-1:0]         frameData,
  output logic                     frameValid,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             lsb_mode;
  logic             complete;

`ifdef FRAMED_SR_LSB_FIRST_EN
  assign lsb_mode = lsbFirst;
`else
  logic unused_lsb_first;
  assign unused_lsb_first = lsbFirst;
  assign lsb_mode = 1'b0;
`endif

  always_comb begin
    shift_d   = shift_q;
    count_d   = count_q;
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    if (parallelLoad) begin
      shift_d = parallelDataIn;
      count_d = '0;
    end else if (peripheralClkEdge) begin
      shift_d  = lsb_mode ? {serialDataIn, shift_q[WIDTH-1:1]}
                          : {shift_q[WIDTH-2:0], serialDataIn};
      complete = (count_q == LAST_BIT);
      count_d  = complete ? '0 : count_q + 1'b1;
    end

    // An ack in the completion cycle frees the holding register for the new frame.
    if (complete) begin
      if (!valid_q || frameAck) begin
        frame_d = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (frameAck) begin
      valid_d = 1'b0;
    end

    done_d = complete;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      count_q   <= count_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallelDataOut = shift_q;
  assign serialDataOut   = lsb_mode ? shift_q[0] : shift_q[WIDTH-1];
  assign bitCount        = count_q;
  assign frameDone       = done_q;
  assign frameData       = frame_q;
  assign frameValid      = valid_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_framed_shiftregister.sv
// tb/tb_framed_shiftregister.sv - self-checking bench for framed_shiftregister (WIDTH=8)
module tb_framed_shiftregister;

  localparam int W = 8;
`ifdef FRAMED_SR_LSB_FIRST_EN
  localparam bit LSB_EN = 1'b1;
`else
  localparam bit LSB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, stb_i, load_i, sin_i, lsb_i, ack_i;
  logic [W-1:0] pdin_i;
  logic [W-1:0] pout, fdata;
  logic         sout, fdone, fvalid, ovr;
  logic [2:0]   bcnt;

  always #5 clk = ~clk;

  framed_shiftregister #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .peripheralClkEdge(stb_i), .parallelLoad(load_i),
    .parallelDataIn(pdin_i), .serialDataIn(sin_i), .lsbFirst(lsb_i), .frameAck(ack_i),
    .parallelDataOut(pout), .serialDataOut(sout), .bitCount(bcnt), .frameDone(fdone),
    .frameData(fdata), .frameValid(fvalid), .overrun(ovr)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: plain integer arithmetic over the frame rules.
  int m_reg, m_cnt, m_frame;
  bit m_done, m_valid, m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_sout(input bit lsb);
    return (LSB_EN && lsb) ? (m_reg % 2) : (m_reg / (1 << (W - 1)));
  endfunction

  task automatic model_step(input bit rst, ld, stb, input int pdin, input bit sin, lsb, ack);
    bit complete = 0;
    if (rst) begin
      m_reg = 0; m_cnt = 0; m_frame = 0; m_done = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    if (ld) begin
      m_reg = pdin; m_cnt = 0;
    end else if (stb) begin
      if (LSB_EN && lsb) m_reg = m_reg / 2 + sin * (1 << (W - 1));
      else               m_reg = (m_reg * 2 + sin) % (1 << W);
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin m_cnt = 0; complete = 1; end
    end
    if (complete) begin
      if (!m_valid || ack) begin m_frame = m_reg; m_valid = 1; end
      else m_ovr = 1;
    end else if (ack) m_valid = 0;
    m_done = complete;
  endtask

  // Entered and left at posedge+1.
  task automatic apply(input bit rst, ld, stb, input logic [W-1:0] pdin, input bit sin, lsb, ack);
    reset = rst; load_i = ld; stb_i = stb; pdin_i = pdin; sin_i = sin; lsb_i = lsb; ack_i = ack;
    #1;
    chk("serialDataOut", 32'(sout), 32'(model_sout(lsb)));
    model_step(rst, ld, stb, int'(pdin), sin, lsb, ack);
    @(posedge clk); #1;
    chk("parallelDataOut", 32'(pout), 32'(m_reg));
    chk("bitCount", 32'(bcnt), 32'(m_cnt));
    chk("frameDone", 32'(fdone), 32'(m_done));
    chk("frameData", 32'(fdata), 32'(m_frame));
    chk("frameValid", 32'(fvalid), 32'(m_valid));
    chk("overrun", 32'(ovr), 32'(m_ovr));
  endtask

  typedef struct {
    bit rst, ld, stb, sin, ack;
    logic [W-1:0] pdin;
    logic [W-1:0] e_pout, e_frame;
    logic [2:0]   e_cnt;
    bit e_done, e_valid, e_sout;
  } vec_t;

  function automatic vec_t mk(bit rst, ld, stb, logic [W-1:0] pdin, bit sin, ack,
                              bit e_sout, logic [W-1:0] e_pout, logic [2:0] e_cnt,
                              bit e_done, bit e_valid, logic [W-1:0] e_frame);
    vec_t v;
    v.rst = rst; v.ld = ld; v.stb = stb; v.pdin = pdin; v.sin = sin; v.ack = ack;
    v.e_sout = e_sout; v.e_pout = e_pout; v.e_cnt = e_cnt;
    v.e_done = e_done; v.e_valid = e_valid; v.e_frame = e_frame;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    // reset, load A5, shift 1,0,0,1,0,0,1,1 MSB-first, idle, ack
    tbl[0]  = mk(1,0,0,8'h00,0,0, 0, 8'h00,0, 0,0,8'h00);
    tbl[1]  = mk(0,1,0,8'hA5,0,0, 0, 8'hA5,0, 0,0,8'h00);
    tbl[2]  = mk(0,0,1,8'h00,1,0, 1, 8'h4B,1, 0,0,8'h00);
    tbl[3]  = mk(0,0,1,8'h00,0,0, 0, 8'h96,2, 0,0,8'h00);
    tbl[4]  = mk(0,0,1,8'h00,0,0, 1, 8'h2C,3, 0,0,8'h00);
    tbl[5]  = mk(0,0,1,8'h00,1,0, 0, 8'h59,4, 0,0,8'h00);
    tbl[6]  = mk(0,0,1,8'h00,0,0, 0, 8'hB2,5, 0,0,8'h00);
    tbl[7]  = mk(0,0,1,8'h00,0,0, 1, 8'h64,6, 0,0,8'h00);
    tbl[8]  = mk(0,0,1,8'h00,1,0, 0, 8'hC9,7, 0,0,8'h00);
    tbl[9]  = mk(0,0,1,8'h00,1,0, 1, 8'h93,0, 1,1,8'h93);
    tbl[10] = mk(0,0,0,8'h00,0,0, 1, 8'h93,0, 0,1,8'h93);
    tbl[11] = mk(0,0,0,8'h00,0,1, 1, 8'h93,0, 0,0,8'h93);
    tbl[12] = mk(0,0,0,8'h00,0,0, 1, 8'h93,0, 0,0,8'h93);

    reset = 1; load_i = 0; stb_i = 0; pdin_i = '0; sin_i = 0; lsb_i = 0; ack_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; load_i = tbl[i].ld; stb_i = tbl[i].stb; pdin_i = tbl[i].pdin;
      sin_i = tbl[i].sin; lsb_i = 0; ack_i = tbl[i].ack;
      #1;
      chk("tbl sout", 32'(sout), 32'(tbl[i].e_sout));
      apply(tbl[i].rst, tbl[i].ld, tbl[i].stb, tbl[i].pdin, tbl[i].sin, 0, tbl[i].ack);
      chk("tbl pout", 32'(pout), 32'(tbl[i].e_pout));
      chk("tbl bitCount", 32'(bcnt), 32'(tbl[i].e_cnt));
      chk("tbl frameDone", 32'(fdone), 32'(tbl[i].e_done));
      chk("tbl frameValid", 32'(fvalid), 32'(tbl[i].e_valid));
      chk("tbl frameData", 32'(fdata), 32'(tbl[i].e_frame));
      chk("tbl overrun", 32'(ovr), 32'h0);
    end

    // LSB-first single shift
    apply(1, 0, 0, 0, 0, 1, 0);
    apply(0, 1, 0, 8'h01, 0, 1, 0);
    chk("lsb sout before", 32'(sout), LSB_EN ? 32'h1 : 32'h0);
    apply(0, 0, 1, 0, 1, 1, 0);
    chk("lsb pout", 32'(pout), LSB_EN ? 32'h80 : 32'h03);
    chk("lsb bitCount", 32'(bcnt), 32'h1);
    chk("lsb sout after", 32'(sout), 32'h0);

    // Overrun: two frames back to back with no ack
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * W; i++) apply(0, 0, 1, 0, (i < W) ? (i % 2) : 1, 0, 0);
    chk("ovr flag", 32'(ovr), 32'h1);
    chk("ovr first frame", 32'(fdata), 32'h55);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("ovr ack valid", 32'(fvalid), 32'h0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("ovr sticky", 32'(ovr), 32'h1);

    // Load beats a simultaneous edge
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 1, 0, 0);
    apply(0, 1, 1, 8'h3C, 1, 0, 0);
    chk("load pout", 32'(pout), 32'h3C);
    chk("load bitCount", 32'(bcnt), 32'h0);
    chk("load no done", 32'(fdone), 32'h0);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 1, 0, 0);
    apply(1, 0, 1, 0, 1, 0, 0);
    chk("rst pout", 32'(pout), 32'h0);
    chk("rst bitCount", 32'(bcnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, 1, 0, 0);
      chk("rst no done", 32'(fdone), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), W'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0) ? ~lsb_i : lsb_i,
            ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
